// File: rtl/h264_mb_input_buffer.sv
// Luma macroblock-row buffer: fills 16 raster lines, then replays them
// as 4x4 sub-blocks in H.264 order, one 4-pixel row per output word.
module h264_mb_input_buffer #(
    parameter int MB_WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        strobe_i,
    input  logic        newline_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    input  logic        ready_i,
    output logic        strobe_o,
    output logic [31:0] data_o,
    output logic [1:0]  xx_o,
    output logic [1:0]  yy_o,
    output logic [1:0]  row_o,
    output logic [((MB_WIDTH > 1) ? $clog2(MB_WIDTH) : 1)-1:0] mbx_o,
    output logic        mb_start_o,
    output logic        mb_done_o,
    output logic        err_o
);
    localparam int WPL   = 4 * MB_WIDTH;
    localparam int CW    = $clog2(WPL);
    localparam int DEPTH = 16 * WPL;
    localparam int AW    = $clog2(DEPTH);
    localparam int MW    = (MB_WIDTH > 1) ? $clog2(MB_WIDTH) : 1;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]    state;
    logic [3:0]    line;
    logic [CW-1:0] col;
    logic [MW-1:0] mbx;
    logic [3:0]    submb;
    logic [1:0]    row;
    logic [3:0]    submb_q;
    logic [1:0]    xx;
    logic [1:0]    yy;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic          abort;
    logic          wr_en;
    logic          issue;
    logic          last_col;
    logic          last_rd;

    logic [31:0] mem [DEPTH];

    assign abort    = newline_i & ~strobe_i;
    assign wr_en    = (state == FILL) & strobe_i;
    assign issue    = (state == DRAIN) & ready_i & ~abort;
    assign last_col = (col == CW'(WPL - 1));
    assign last_rd  = (mbx == MW'(MB_WIDTH - 1)) &
                      (submb == 4'hf) & (row == 2'd3);

    assign xx = {submb[2], submb[0]};
    assign yy = {submb[3], submb[1]};

    assign wr_addr = AW'(line) * AW'(WPL) + AW'(col);
    // line = 4*yy+row is just the concatenation {yy,row}
    assign rd_addr = AW'({yy, row}) * AW'(WPL) +
                     AW'(mbx) * AW'(4) + AW'(xx);

    assign ready_o = (state == FILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
            line  <= '0;
            col   <= '0;
            mbx   <= '0;
            submb <= '0;
            row   <= '0;
            err_o <= 1'b0;
        end else begin
            if (strobe_i && state == DRAIN)
                err_o <= 1'b1;
            if (abort) begin
                state <= FILL;
                line  <= '0;
                col   <= '0;
                mbx   <= '0;
                submb <= '0;
                row   <= '0;
            end else if (wr_en) begin
                if (last_col) begin
                    col  <= '0;
                    line <= line + 4'd1;
                    if (line == 4'hf)
                        state <= DRAIN;
                end else begin
                    col <= col + CW'(1);
                end
            end else if (issue) begin
                if (last_rd) begin
                    state <= FILL;
                    mbx   <= '0;
                    submb <= '0;
                    row   <= '0;
                end else begin
                    {mbx, submb, row} <= {mbx, submb, row} + (MW + 6)'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_o <= 1'b0;
            data_o   <= '0;
            xx_o     <= '0;
            yy_o     <= '0;
            row_o    <= '0;
            mbx_o    <= '0;
            submb_q  <= '0;
        end else begin
            strobe_o <= issue;
            if (issue) begin
                data_o  <= mem[rd_addr];
                xx_o    <= xx;
                yy_o    <= yy;
                row_o   <= row;
                mbx_o   <= mbx;
                submb_q <= submb;
            end
        end
    end

    assign mb_start_o = strobe_o & (submb_q == 4'h0) & (row_o == 2'd0);
    assign mb_done_o  = strobe_o & (submb_q == 4'hf) & (row_o == 2'd3);

endmodule

// File: tb/tb_h264_mb_input_buffer.sv
// Bench for h264_mb_input_buffer: vector table, hand sequences and
// randomized fills checked against a sub-block order model.
module tb_h264_mb_input_buffer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe_i = 1'b0;
    logic        newline_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        ready_i = 1'b1;
    logic        ready_o, strobe_o, mb_start_o, mb_done_o, err_o;
    logic [31:0] data_o;
    logic [1:0]  xx_o, yy_o, row_o;
    logic [0:0]  mbx_o;

    logic        b_strobe = 1'b0;
    logic        b_newline = 1'b0;
    logic [31:0] b_data = '0;
    logic        b_ready = 1'b1;
    logic        b_ready_o, b_strobe_o, b_start, b_done, b_err;
    logic [31:0] b_data_o;
    logic [1:0]  b_xx, b_yy, b_row;
    logic [0:0]  b_mbx;

    always #5 clk = ~clk;

    h264_mb_input_buffer #(.MB_WIDTH(1)) dut (
        .clk(clk), .reset(reset), .strobe_i(strobe_i),
        .newline_i(newline_i), .data_i(data_i), .ready_o(ready_o),
        .ready_i(ready_i), .strobe_o(strobe_o), .data_o(data_o),
        .xx_o(xx_o), .yy_o(yy_o), .row_o(row_o), .mbx_o(mbx_o),
        .mb_start_o(mb_start_o), .mb_done_o(mb_done_o), .err_o(err_o)
    );

    h264_mb_input_buffer #(.MB_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .strobe_i(b_strobe),
        .newline_i(b_newline), .data_i(b_data), .ready_o(b_ready_o),
        .ready_i(b_ready), .strobe_o(b_strobe_o), .data_o(b_data_o),
        .xx_o(b_xx), .yy_o(b_yy), .row_o(b_row), .mbx_o(b_mbx),
        .mb_start_o(b_start), .mb_done_o(b_done), .err_o(b_err)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  xx, yy, row;
        logic        mbx, st, dn, rdy;
        int          cyc;
    } obs_t;

    typedef struct {
        int          idx;
        logic [7:0]  ln, cl;
        logic [1:0]  xx, yy;
        logic        st, dn;
    } vec_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t got[$];
    obs_t got2[$];
    logic [31:0] pix [16][8];
    vec_t vt [9];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) got.delete();
        else if (strobe_o)
            got.push_back('{data_o, xx_o, yy_o, row_o, mbx_o,
                            mb_start_o, mb_done_o, ready_o, cyc});
    end

    always @(negedge clk) begin
        if (reset) got2.delete();
        else if (b_strobe_o)
            got2.push_back('{b_data_o, b_xx, b_yy, b_row, b_mbx,
                             b_start, b_done, b_ready_o, cyc});
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        strobe_i = 1'b0;
        newline_i = 1'b0;
        b_strobe = 1'b0;
        ready_i = 1'b1;
        b_ready = 1'b1;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic fill(input int sel, input int n, input int wpl,
                        input bit rnd, output int t_last);
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            int ln, cl;
            logic [31:0] w;
            ln = i / wpl;
            cl = i % wpl;
            w = rnd ? $urandom : {8'(ln), 8'(cl), 16'h0};
            pix[ln][cl] = w;
            if (sel == 0) begin strobe_i = 1'b1; data_i = w; end
            else begin b_strobe = 1'b1; b_data = w; end
            t_last = cyc;
            tick;
        end
        strobe_i = 1'b0;
        b_strobe = 1'b0;
    endtask

    task automatic wait_n(input int sel, input int n);
        int k;
        k = 0;
        while (((sel == 0) ? got.size() : got2.size()) < n && k < 2000) begin
            tick;
            k++;
        end
        repeat (3) tick;
        check("count", (sel == 0) ? got.size() : got2.size(), n);
    endtask

    function automatic logic [38:0] exp_word(input int k);
        int m, r;
        logic [3:0] b;
        logic [1:0] xx, yy;
        m = k / 64;
        b = 4'((k % 64) / 4);
        r = k % 4;
        xx = {b[2], b[0]};
        yy = {b[3], b[1]};
        return {1'(m), xx, yy, 2'(r), pix[4 * yy + r][4 * m + xx]};
    endfunction

    task automatic check_seq(input int sel, input int n);
        for (int k = 0; k < n; k++) begin
            obs_t o;
            if (k >= ((sel == 0) ? got.size() : got2.size())) break;
            o = (sel == 0) ? got[k] : got2[k];
            check($sformatf("seq%0d", k),
                  {o.mbx, o.xx, o.yy, o.row, o.d}, exp_word(k));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int t, n, ns, nd;
        obs_t o;
        vt[0] = '{0,  8'd0,  8'd0, 2'd0, 2'd0, 1'b1, 1'b0};
        vt[1] = '{1,  8'd1,  8'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        vt[2] = '{2,  8'd2,  8'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        vt[3] = '{3,  8'd3,  8'd0, 2'd0, 2'd0, 1'b0, 1'b0};
        vt[4] = '{4,  8'd0,  8'd1, 2'd1, 2'd0, 1'b0, 1'b0};
        vt[5] = '{8,  8'd4,  8'd0, 2'd0, 2'd1, 1'b0, 1'b0};
        vt[6] = '{16, 8'd0,  8'd2, 2'd2, 2'd0, 1'b0, 1'b0};
        vt[7] = '{32, 8'd8,  8'd0, 2'd0, 2'd2, 1'b0, 1'b0};
        vt[8] = '{63, 8'd15, 8'd3, 2'd3, 2'd3, 1'b0, 1'b1};

        do_reset;
        check("rst_ctl", {strobe_o, mb_start_o, mb_done_o, err_o, ready_o},
              5'b00001);
        check("rst_dat", {data_o, xx_o, yy_o, row_o, mbx_o}, '0);

        // basic order and latency
        fill(0, 64, 4, 0, t);
        wait_n(0, 64);
        for (int i = 0; i < 9; i++) begin
            o = got[vt[i].idx];
            check($sformatf("order%0d", vt[i].idx),
                  {o.d, o.xx, o.yy, o.st, o.dn},
                  {vt[i].ln, vt[i].cl, 16'h0, vt[i].xx, vt[i].yy,
                   vt[i].st, vt[i].dn});
        end
        ns = 0;
        nd = 0;
        foreach (got[i]) begin
            ns += int'(got[i].st);
            nd += int'(got[i].dn);
        end
        check("starts", ns, 1);
        check("dones", nd, 1);
        check("lat_first", got[0].cyc, t + 2);
        check("lat_last", got[63].cyc, t + 65);
        check("rdy_last", got[63].rdy, 1'b1);
        check("rdy_drain", got[62].rdy, 1'b0);
        check_seq(0, 64);

        // stall after word 10
        do_reset;
        fill(0, 64, 4, 0, t);
        while (cyc < t + 12) tick;
        ready_i = 1'b0;
        while (cyc < t + 17) tick;
        ready_i = 1'b1;
        wait_n(0, 64);
        check("stall_w10", got[10].cyc, t + 12);
        check("stall_w11", got[11].cyc, t + 18);
        check_seq(0, 64);

        // randomized data with random backpressure
        for (int rep = 0; rep < 3; rep++) begin
            int k;
            do_reset;
            fill(0, 64, 4, 1, t);
            k = 0;
            while (got.size() < 64 && k < 1000) begin
                ready_i = 1'($urandom_range(0, 1));
                tick;
                k++;
            end
            ready_i = 1'b1;
            wait_n(0, 64);
            check_seq(0, 64);
        end

        // abort during fill
        do_reset;
        fill(0, 20, 4, 1, t);
        newline_i = 1'b1;
        tick;
        newline_i = 1'b0;
        check("abort_fill_rdy", ready_o, 1'b1);
        fill(0, 64, 4, 0, t);
        wait_n(0, 64);
        check_seq(0, 64);

        // abort during drain
        do_reset;
        fill(0, 64, 4, 0, t);
        n = 0;
        while (got.size() < 10 && n < 200) begin tick; n++; end
        newline_i = 1'b1;
        tick;
        newline_i = 1'b0;
        check("abort_strobe", strobe_o, 1'b0);
        check("abort_rdy", ready_o, 1'b1);
        n = got.size();
        repeat (5) tick;
        check("abort_quiet", got.size(), n);

        // reset during drain
        do_reset;
        fill(0, 64, 4, 0, t);
        repeat (10) tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("rstd_ctl", {strobe_o, err_o, ready_o}, 3'b001);
        repeat (5) tick;
        check("rstd_quiet", got.size(), 0);

        // input during drain sets sticky error
        do_reset;
        fill(0, 64, 4, 0, t);
        repeat (5) tick;
        strobe_i = 1'b1;
        data_i = 32'hbad0_bad0;
        repeat (3) tick;
        strobe_i = 1'b0;
        check("err_set", err_o, 1'b1);
        wait_n(0, 64);
        check_seq(0, 64);
        newline_i = 1'b1;
        tick;
        newline_i = 1'b0;
        check("err_sticky", err_o, 1'b1);
        do_reset;
        check("err_clr", err_o, 1'b0);

        // two macroblocks per row
        fill(1, 128, 8, 0, t);
        wait_n(1, 128);
        check("mb2_w64", got2[64].d, 32'h0004_0000);
        ns = 0;
        nd = 0;
        foreach (got2[i]) begin
            ns += int'(got2[i].st);
            nd += int'(got2[i].dn);
        end
        check("mb2_starts", ns, 2);
        check("mb2_dones", nd, 2);
        check_seq(1, 128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/h264_mb_input_buffer.md
# h264_mb_input_buffer

Luma input stage that sits directly upstream of the intra4x4 controller. It accepts raster-order picture lines, four pixels per word, and stores one full macroblock row of 16 lines. It then replays that row macroblock by macroblock, emitting 4x4 sub-blocks in H.264 sub-block order, one 4-pixel row per word. Each word carries its sub-block coordinates, so the downstream controller can walk `submb`/`xx`/`yy` without re-deriving addresses.

## Interface
Parameters:
- `MB_WIDTH`, default 4: picture width in macroblocks. Width is 16*`MB_WIDTH` pixels, which is 4*`MB_WIDTH` words per line.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `strobe_i`  in  1  input word valid.
- `newline_i`  in  1  row restart marker; only acts when `strobe_i`=0.
- `data_i`  in  32  four pixels; leftmost pixel in [31:24].
- `ready_o`  out  1  buffer accepting input (state FILL).
- `ready_i`  in  1  downstream may take another word.
- `strobe_o`  out  1  output word valid.
- `data_o`  out  32  one 4-pixel row of a sub-block, same byte order as `data_i`.
- `xx_o`  out  2  sub-block column within the MB.
- `yy_o`  out  2  sub-block row within the MB.
- `row_o`  out  2  pixel row within the sub-block.
- `mbx_o`  out  $clog2(`MB_WIDTH`) (min 1)  macroblock index in the row.
- `mb_start_o`  out  1  pulse with the first word of each MB.
- `mb_done_o`  out  1  pulse with the 64th word of each MB.
- `err_o`  out  1  sticky: a word arrived while `ready_o`=0.

## Operation
Storage and states:
- Storage is 16*4*`MB_WIDTH` words of 32 bits, single-port style, with synchronous read (1-cycle latency).
- The write address is line*4*`MB_WIDTH`+col.
- The block has two states, FILL and DRAIN. Reset enters FILL, with all counters at 0.

FILL state:
- `ready_o`=1.
- Each `strobe_i` writes `data_i` at (line, col) and then increments col.
- When col reaches 4*`MB_WIDTH`-1, col wraps to 0 and line increments.
- The write of line 15, last col, moves the state to DRAIN.

DRAIN state:
- `ready_o`=0.
- The read counter is {mbx, submb[3:0], row[1:0]}. It advances only on cycles with `ready_i`=1.
- Sub-block coordinates: xx={submb[2],submb[0]}, yy={submb[3],submb[1]}.
- Read address: line=4*yy+row, col=4*mbx+xx.
- Issuing the read for mbx=`MB_WIDTH`-1, submb=15, row=3 returns the block to FILL the next cycle, with all counters at 0.

Output register:
- `strobe_o`, `data_o`, `xx_o`, `yy_o`, `row_o` and `mbx_o` are registered.
- They are valid exactly one cycle after the read issues.
- `strobe_o`=0 on every cycle that follows a non-issue cycle.

Output pulses:
- `mb_start_o` = `strobe_o` with submb=0, row=0.
- `mb_done_o` = `strobe_o` with submb=15, row=3.

Boundary conditions:
- `newline_i`=1 with `strobe_i`=0, in either state, aborts to FILL with all counters at 0. Any in-flight read is suppressed, so `strobe_o`=0 next cycle. Stored data is not cleared.
- `newline_i`=1 together with `strobe_i`=1: `newline_i` is ignored and the word is accepted normally.
- `strobe_i`=1 while in DRAIN: the word is dropped and `err_o` is set. `err_o` clears only on reset.
- `reset` mid-DRAIN: the block returns to FILL next cycle. No further `strobe_o` is produced.

## Timing
Reset values:
- `strobe_o`, `mb_start_o`, `mb_done_o`, `err_o` are 0.
- `data_o`, `xx_o`, `yy_o`, `row_o`, `mbx_o` are 0.
- `ready_o`=1, since the state is FILL.

DRAIN timing, with the last input word accepted at cycle T:
- DRAIN starts at T+1, and the first read issues at T+1.
- The first `strobe_o` and `mb_start_o` occur at T+2.
- With `ready_i` held at 1, the output is 64 consecutive words per MB.
- The last word and its `mb_done_o` occur at T+1+64*`MB_WIDTH`.
- `ready_o` returns to 1 in that same cycle.

Flow control:
- `ready_i` is sampled at issue time. Dropping `ready_i` still lets the already-issued word appear on the next cycle, so exactly one word is in flight.
- Downstream must tolerate one word after deasserting `ready_i`.

Throughput: one input word per cycle and one output word per cycle. There is no overlap: fill and drain are serialized.

## Test plan
For all scenarios, `MB_WIDTH`=1 and each input word is {line[7:0], col[7:0], 16'h0}.

1. **Basic order.** Fill 16 lines of 4 words, `ready_i`=1.
   - Words 0–3 are {0,0},{1,0},{2,0},{3,0} with xx=0, yy=0.
   - Word 4 is {0,1} with xx=1, yy=0.
   - Word 8 is {4,0} with xx=0, yy=1.
   - Word 63 is {15,3} with `mb_done_o`=1.
   - `mb_start_o` is asserted only on word 0.
2. **Latency.** Last input at cycle T.
   - First `strobe_o` at T+2.
   - `ready_o`=1 and the last `strobe_o` both at T+65.
3. **Stall.** Hold `ready_i`=0 for 5 cycles after word 10 issues.
   - Word 10 still appears, then there is a 5-cycle gap.
   - Word 11 then continues in order; no word is lost or duplicated.
4. **Abort.**
   - Pulse `newline_i` (with `strobe_i`=0) after 20 input words. Then 64 fresh words drain correctly, containing only the new data.
   - Pulse `newline_i` mid-DRAIN. `strobe_o`=0 from the next cycle and `ready_o`=1.
5. **Error.** Drive `strobe_i` during DRAIN.
   - `err_o`=1 and stays set; the output sequence is unchanged.
   - `reset` clears `err_o`.
6. **Multi-MB.** With `MB_WIDTH`=2:
   - `mbx_o` is 0 for words 0–63 and 1 for words 64–127.
   - Word 64 is {0,4}.
   - `mb_done_o` fires twice.
